// File: rtl/dpsk_frame_sync.sv
// dpsk_frame_sync: DPSK bit slicer, sync-word hunter and payload deframer; define DPSK_DIFF_DECODE_EN to differentially decode in this block
module dpsk_frame_sync #(
  parameter logic [31:0] SYNC_WORD    = 32'h0000_EB90,
  parameter int          SYNC_LEN     = 16,
  parameter int          MISMATCH_MAX = 1,
  parameter int          FRAME_BYTES  = 8,
  parameter int          LOS_CYCLES   = 180
) (
  input  logic       clk_12,
  input  logic       rst_i,
  input  logic       data_i,
  input  logic       syn_i,
  output logic       bit_o,
  output logic       bit_vld_o,
  output logic [7:0] byte_o,
  output logic       byte_vld_o,
  output logic       frame_start_o,
  output logic       frame_end_o,
  output logic       locked_o,
  output logic       los_o
);
  localparam int GW = $clog2(LOS_CYCLES + 1);
  localparam logic [5:0] FILL_MAX = 6'(SYNC_LEN);
  localparam logic [5:0] ERR_MAX = 6'(MISMATCH_MAX);
  localparam logic [7:0] LAST_BYTE = 8'(FRAME_BYTES - 1);
  localparam logic [GW-1:0] GAP_MAX = GW'(LOS_CYCLES);
  localparam logic [SYNC_LEN-1:0] SYNC_PAT = SYNC_WORD[SYNC_LEN-1:0];

  typedef enum logic {HUNT, PAYLOAD} state_t;

  state_t state_q, state_d;
  logic data_s1_q, data_s2_q, syn_s1_q, syn_s2_q, syn_s3_q;
  logic [SYNC_LEN-1:0] sr_q, sr_d, sr_nx;
  logic [5:0] fill_q, fill_d, fill_nx;
  logic [7:0] bsr_q, bsr_d, bsr_nx;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] byte_cnt_q, byte_cnt_d;
  logic [GW-1:0] gap_q, gap_d;
  logic bit_q, bit_d, bit_vld_q, bit_vld_d;
  logic [7:0] byte_q, byte_d;
  logic byte_vld_q, byte_vld_d, start_q, start_d, end_q, end_d;
  logic locked_q, locked_d, los_q, los_d;
  logic rise, dec_bit, match;

  function automatic logic [5:0] popcount(input logic [SYNC_LEN-1:0] v);
    logic [5:0] n;
    n = '0;
    for (int i = 0; i < SYNC_LEN; i++) n = n + 6'(v[i]);
    return n;
  endfunction

  // Two-flop synchronisers on the asynchronous data and bit clock, plus one extra stage on syn for edge detect
  always_ff @(posedge clk_12) begin
    if (rst_i) begin
      data_s1_q <= 1'b0;
      data_s2_q <= 1'b0;
      syn_s1_q  <= 1'b0;
      syn_s2_q  <= 1'b0;
      syn_s3_q  <= 1'b0;
    end else begin
      data_s1_q <= data_i;
      data_s2_q <= data_s1_q;
      syn_s1_q  <= syn_i;
      syn_s2_q  <= syn_s1_q;
      syn_s3_q  <= syn_s2_q;
    end
  end

  assign rise = syn_s2_q & ~syn_s3_q;

`ifdef DPSK_DIFF_DECODE_EN
  logic prev_raw_q;

  // Previous raw sample survives LOS so decoding stays continuous across a signal dropout
  always_ff @(posedge clk_12) begin
    if (rst_i) prev_raw_q <= 1'b0;
    else if (rise) prev_raw_q <= data_s2_q;
  end

  assign dec_bit = data_s2_q ^ prev_raw_q;
`else
  assign dec_bit = data_s2_q;
`endif

  assign sr_nx   = {sr_q[SYNC_LEN-2:0], dec_bit};
  assign bsr_nx  = {bsr_q[6:0], dec_bit};
  assign fill_nx = fill_q == FILL_MAX ? fill_q : fill_q + 6'd1;
  assign match   = fill_nx == FILL_MAX && popcount(sr_nx ^ SYNC_PAT) <= ERR_MAX;

  // State and datapath registers
  always_ff @(posedge clk_12) begin
    if (rst_i) begin
      state_q    <= HUNT;
      sr_q       <= '0;
      fill_q     <= '0;
      bsr_q      <= '0;
      bit_cnt_q  <= '0;
      byte_cnt_q <= '0;
      gap_q      <= '0;
      bit_q      <= 1'b0;
      bit_vld_q  <= 1'b0;
      byte_q     <= '0;
      byte_vld_q <= 1'b0;
      start_q    <= 1'b0;
      end_q      <= 1'b0;
      locked_q   <= 1'b0;
      los_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      sr_q       <= sr_d;
      fill_q     <= fill_d;
      bsr_q      <= bsr_d;
      bit_cnt_q  <= bit_cnt_d;
      byte_cnt_q <= byte_cnt_d;
      gap_q      <= gap_d;
      bit_q      <= bit_d;
      bit_vld_q  <= bit_vld_d;
      byte_q     <= byte_d;
      byte_vld_q <= byte_vld_d;
      start_q    <= start_d;
      end_q      <= end_d;
      locked_q   <= locked_d;
      los_q      <= los_d;
    end
  end

  // Hunt/payload sequencing; a bit arriving in the LOS-threshold cycle takes priority over the LOS
  always_comb begin
    state_d    = state_q;
    sr_d       = sr_q;
    fill_d     = fill_q;
    bsr_d      = bsr_q;
    bit_cnt_d  = bit_cnt_q;
    byte_cnt_d = byte_cnt_q;
    bit_d      = bit_q;
    bit_vld_d  = 1'b0;
    byte_d     = byte_q;
    byte_vld_d = 1'b0;
    start_d    = 1'b0;
    end_d      = 1'b0;
    gap_d      = rise ? '0 : (gap_q == GAP_MAX ? gap_q : gap_q + GW'(1));
    los_d      = rise ? 1'b0 : (gap_d == GAP_MAX ? 1'b1 : los_q);
    if (rise) begin
      bit_d     = dec_bit;
      bit_vld_d = 1'b1;
      sr_d      = sr_nx;
      fill_d    = fill_nx;
      if (state_q == HUNT) begin
        if (match) begin
          start_d    = 1'b1;
          state_d    = PAYLOAD;
          bit_cnt_d  = '0;
          byte_cnt_d = '0;
        end
      end else begin
        bsr_d     = bsr_nx;
        bit_cnt_d = bit_cnt_q + 3'd1;
        if (bit_cnt_q == 3'd7) begin
          byte_d     = bsr_nx;
          byte_vld_d = 1'b1;
          byte_cnt_d = byte_cnt_q + 8'd1;
          if (byte_cnt_q == LAST_BYTE) begin
            end_d   = 1'b1;
            state_d = HUNT;
            fill_d  = '0;
          end
        end
      end
    end else if (gap_d == GAP_MAX) begin
      state_d    = HUNT;
      fill_d     = '0;
      bsr_d      = '0;
      bit_cnt_d  = '0;
      byte_cnt_d = '0;
    end
    locked_d = state_d == PAYLOAD || end_d;
  end

  assign bit_o         = bit_q;
  assign bit_vld_o     = bit_vld_q;
  assign byte_o        = byte_q;
  assign byte_vld_o    = byte_vld_q;
  assign frame_start_o = start_q;
  assign frame_end_o   = end_q;
  assign locked_o      = locked_q;
  assign los_o         = los_q;
endmodule

// File: tb/tb_dpsk_frame_sync.sv
// tb_dpsk_frame_sync: directed frames against a bit-level behavioural model of the frame synchroniser
module tb_dpsk_frame_sync;
  logic clk_12 = 1'b0, rst_i = 1'b1, data_i = 1'b0, syn_i = 1'b0;
  logic bit_o, bit_vld_o, byte_vld_o, frame_start_o, frame_end_o, locked_o, los_o;
  logic [7:0] byte_o;
  int tests = 0, fails = 0;

  dpsk_frame_sync dut (
    .clk_12(clk_12), .rst_i(rst_i), .data_i(data_i), .syn_i(syn_i),
    .bit_o(bit_o), .bit_vld_o(bit_vld_o), .byte_o(byte_o), .byte_vld_o(byte_vld_o),
    .frame_start_o(frame_start_o), .frame_end_o(frame_end_o),
    .locked_o(locked_o), .los_o(los_o)
  );

  always #5 clk_12 = ~clk_12;

  int cyc = 0, ev_cyc = -1, last = 0, fill = 0, nbit = 0, nbyte = 0, n_start = 0, n_end = 0;
  logic ev_raw = 1'b0, in_frame = 1'b0, los_seen = 1'b0;
  logic [15:0] win = '0;
  logic [7:0] acc = '0, e_byte = '0;
  logic e_bit = 0, e_vld = 0, e_bvld = 0, e_start = 0, e_end = 0, e_locked = 0, e_los = 0;
  logic [7:0] got_bytes[$];
  logic got_bits[$];
`ifdef DPSK_DIFF_DECODE_EN
  logic mprev = 1'b0, tx_prev = 1'b0;
`endif

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // Model: bit accepted three edges after syn_i is driven high; compare every cycle
  always @(posedge clk_12) begin
    logic b;
    #1;
    cyc++;
    if (rst_i) begin
      in_frame = 0; win = '0; fill = 0; nbit = 0; nbyte = 0; acc = '0; last = cyc;
      {e_bit, e_vld, e_bvld, e_start, e_end, e_locked, e_los} = '0;
      e_byte = '0;
`ifdef DPSK_DIFF_DECODE_EN
      mprev = 1'b0;
`endif
    end else begin
      {e_vld, e_bvld, e_start, e_end} = '0;
      if (ev_cyc == cyc) begin
`ifdef DPSK_DIFF_DECODE_EN
        b = ev_raw ^ mprev;
        mprev = ev_raw;
`else
        b = ev_raw;
`endif
        last = cyc; e_los = 0; e_bit = b; e_vld = 1;
        got_bits.push_back(b);
        win = {win[14:0], b};
        if (fill < 16) fill++;
        if (!in_frame) begin
          if (fill == 16 && $countones(win ^ 16'hEB90) <= 1) begin
            e_start = 1; in_frame = 1; nbit = 0; nbyte = 0; n_start++;
          end
        end else begin
          acc = {acc[6:0], b};
          nbit++;
          if (nbit == 8) begin
            nbit = 0; nbyte++; e_byte = acc; e_bvld = 1;
            got_bytes.push_back(acc);
            if (nbyte == 8) begin
              e_end = 1; in_frame = 0; fill = 0; n_end++;
            end
          end
        end
      end else if (cyc - last >= 180) begin
        e_los = 1; los_seen = 1; in_frame = 0; fill = 0; nbit = 0; nbyte = 0;
      end
      e_locked = in_frame || e_end;
    end
    chk("bit_o", bit_o, e_bit);
    chk("bit_vld_o", bit_vld_o, e_vld);
    chk("byte_o", byte_o, e_byte);
    chk("byte_vld_o", byte_vld_o, e_bvld);
    chk("frame_start_o", frame_start_o, e_start);
    chk("frame_end_o", frame_end_o, e_end);
    chk("locked_o", locked_o, e_locked);
    chk("los_o", los_o, e_los);
  end

  task automatic send_raw(input logic r);
    @(negedge clk_12);
    data_i = r; syn_i = 1'b1; ev_raw = r; ev_cyc = cyc + 3;
    repeat (29) @(negedge clk_12);
    syn_i = 1'b0;
    repeat (30) @(negedge clk_12);
  endtask

  task automatic send_bit(input logic b);
`ifdef DPSK_DIFF_DECODE_EN
    tx_prev = tx_prev ^ b;
    send_raw(tx_prev);
`else
    send_raw(b);
`endif
  endtask

  task automatic send_byte(input logic [7:0] v);
    for (int i = 7; i >= 0; i--) send_bit(v[i]);
  endtask

  task automatic send_frame(input logic [15:0] sw, input logic [7:0] first, input logic [7:0] step, input int n);
    for (int i = 15; i >= 0; i--) send_bit(sw[i]);
    for (int i = 0; i < n; i++) send_byte(first + step * 8'(i));
  endtask

  task automatic pulse_rst();
    @(negedge clk_12);
    rst_i = 1'b1;
    @(negedge clk_12);
    rst_i = 1'b0;
`ifdef DPSK_DIFF_DECODE_EN
    tx_prev = 1'b0;
`endif
  endtask

  initial begin
    int base;
    repeat (4) @(negedge clk_12);
    rst_i = 1'b0;
`ifdef DPSK_DIFF_DECODE_EN
    base = got_bits.size();
    send_raw(0); send_raw(1); send_raw(1); send_raw(0);
    chk("diff_bit0", got_bits[base], 0);
    chk("diff_bit1", got_bits[base+1], 1);
    chk("diff_bit2", got_bits[base+2], 0);
    chk("diff_bit3", got_bits[base+3], 1);
    pulse_rst();
`endif
    base = got_bytes.size();
    send_frame(16'hEB90, 8'h01, 8'h01, 8);
    chk("clean_starts", n_start, 1);
    chk("clean_ends", n_end, 1);
    for (int i = 0; i < 8; i++) chk("clean_byte", got_bytes[base+i], i + 1);
    send_frame(16'hEB91, 8'hA0, 8'h11, 8);
    chk("err1_starts", n_start, 2);
    chk("err1_ends", n_end, 2);
    chk("err1_last_byte", got_bytes[base+15], 8'h17);
    send_frame(16'hEB93, 8'h00, 8'h00, 8);
    chk("err2_starts", n_start, 2);
    chk("err2_ends", n_end, 2);
    chk("err2_bytes", got_bytes.size(), base + 16);
    send_frame(16'hEB90, 8'hC1, 8'h01, 3);
    repeat (200) @(negedge clk_12);
    chk("los_seen", los_seen, 1);
    chk("los_flag", los_o, 1);
    chk("los_unlocked", locked_o, 0);
    chk("los_no_end", n_end, 2);
    chk("los_partial_bytes", got_bytes.size(), base + 19);
    send_frame(16'hEB90, 8'h11, 8'h01, 8);
    chk("relock_starts", n_start, 4);
    chk("relock_ends", n_end, 3);
    for (int i = 0; i < 8; i++) chk("relock_byte", got_bytes[base+19+i], 8'h11 + 8'(i));
    send_frame(16'hEB90, 8'h21, 8'h01, 4);
    send_bit(0); send_bit(0); send_bit(1);
    pulse_rst();
    chk("rst_locked", locked_o, 0);
    chk("rst_byte", byte_o, 0);
    chk("rst_no_end", n_end, 3);
    base = got_bytes.size();
    send_frame(16'hEB90, 8'h31, 8'h01, 8);
    chk("post_rst_starts", n_start, 6);
    chk("post_rst_ends", n_end, 4);
    for (int i = 0; i < 8; i++) chk("post_rst_byte", got_bytes[base+i], 8'h31 + 8'(i));
    send_frame(16'hEB90, 8'h41, 8'h01, 8);
    send_frame(16'hEB90, 8'h51, 8'h01, 8);
    chk("b2b_starts", n_start, 8);
    chk("b2b_ends", n_end, 6);
    chk("b2b_bytes", got_bytes.size(), base + 24);
    chk("b2b_first", got_bytes[base+8], 8'h41);
    chk("b2b_last", got_bytes[base+23], 8'h58);
    repeat (200) @(negedge clk_12);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
